// File: rtl/elevator_car_scheduler.sv
// Elevator car scheduler: accumulates floor calls, tracks car position from shaft
// ticks and sequences IDLE / MOVE / DOOR with same-direction preference.
module elevator_car_scheduler #(
    parameter int NUM_FLOORS   = 8,
    parameter int FLOOR_W      = $clog2(NUM_FLOORS),
    parameter int DWELL_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  floor_tick,
    output logic [NUM_FLOORS-1:0] queue_status,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic                  up_ndown,
    output logic                  motor_up,
    output logic                  motor_down,
    output logic                  door_open,
    output logic                  queue_empty,
    output logic                  stop_served,
    output logic                  fault
);

    localparam int DW_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);
    localparam logic [DW_W-1:0]    DWELL_LOAD = DW_W'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVE,
        S_DOOR,
        S_FAULT
    } state_e;

    state_e                  state_q, state_d;
    logic [NUM_FLOORS-1:0]   pend_q, pend_d, pend_nxt;
    logic [FLOOR_W-1:0]      floor_q, floor_d, floor_step;
    logic                    dir_q, dir_d;
    logic [DW_W-1:0]         dwell_q, dwell_d;
    logic                    stop_q, stop_d;
    logic                    above, below, resolved_dir, tick_fault;

    function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
        return {{(NUM_FLOORS-1){1'b0}}, 1'b1} << f;
    endfunction

    // Call geometry relative to the car, plus the checked one-floor step.
    always_comb begin
        pend_nxt = pend_q | call_req;
        above    = 1'b0;
        below    = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pend_nxt[i] && (i > int'(floor_q))) above = 1'b1;
            if (pend_nxt[i] && (i < int'(floor_q))) below = 1'b1;
        end
        if (above && !below)      resolved_dir = 1'b1;
        else if (below && !above) resolved_dir = 1'b0;
        else                      resolved_dir = dir_q;
        floor_step = dir_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
        tick_fault = floor_tick && ((state_q != S_MOVE) ||
                                    ( dir_q && (floor_q == TOP_FLOOR)) ||
                                    (!dir_q && (floor_q == '0)));
    end

    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        pend_d  = pend_nxt;
        floor_d = floor_q;
        dir_d   = dir_q;
        dwell_d = dwell_q;
        stop_d  = 1'b0;
        if (state_q == S_FAULT) begin
            pend_d = pend_q;
        end else if (tick_fault) begin
            state_d = S_FAULT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pend_nxt[floor_q]) begin
                        state_d = S_DOOR;
                        pend_d  = pend_nxt & ~floor_bit(floor_q);
                        dwell_d = DWELL_LOAD;
                        stop_d  = 1'b1;
                    end else if (above || below) begin
                        state_d = S_MOVE;
                        dir_d   = resolved_dir;
                    end
                end
                S_MOVE: begin
                    if (floor_tick) begin
                        floor_d = floor_step;
                        if (pend_nxt[floor_step]) begin
                            state_d = S_DOOR;
                            pend_d  = pend_nxt & ~floor_bit(floor_step);
                            dwell_d = DWELL_LOAD;
                            stop_d  = 1'b1;
                        end
                    end
                end
                S_DOOR: begin
                    // Calls for the floor the doors are open at are absorbed and extend the stop.
                    pend_d = pend_nxt & ~floor_bit(floor_q);
                    if (call_req[floor_q]) begin
                        dwell_d = DWELL_LOAD;
                    end else if (dwell_q == '0) begin
                        state_d = S_IDLE;
                        dir_d   = resolved_dir;
                    end else begin
                        dwell_d = dwell_q - DW_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            floor_q <= '0;
            dir_q   <= 1'b1;
            dwell_q <= '0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            floor_q <= floor_d;
            dir_q   <= dir_d;
            dwell_q <= dwell_d;
            stop_q  <= stop_d;
        end
    end

    always_comb begin
        queue_status  = pend_q;
        current_floor = floor_q;
        up_ndown      = dir_q;
        motor_up      = (state_q == S_MOVE) &&  dir_q;
        motor_down    = (state_q == S_MOVE) && !dir_q;
        door_open     = (state_q == S_DOOR);
        queue_empty   = (pend_q == '0);
        stop_served   = stop_q;
        fault         = (state_q == S_FAULT);
    end

endmodule

// File: tb/tb_elevator_car_scheduler.sv
// Self-checking bench for elevator_car_scheduler: vector table, directed corner
// sequences and randomized traffic against a behavioural car model.
module tb_elevator_car_scheduler;

    localparam int NF = 8;
    localparam int FW = 3;
    localparam int DW = 4;
    localparam int M_IDLE = 0, M_MOVE = 1, M_DOOR = 2, M_FAULT = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [NF-1:0] call_req;
    logic          floor_tick;
    logic [NF-1:0] queue_status;
    logic [FW-1:0] current_floor;
    logic          up_ndown, motor_up, motor_down, door_open;
    logic          queue_empty, stop_served, fault;

    elevator_car_scheduler #(.NUM_FLOORS(NF), .FLOOR_W(FW), .DWELL_CYCLES(DW)) dut (
        .clk(clk), .reset(reset), .call_req(call_req), .floor_tick(floor_tick),
        .queue_status(queue_status), .current_floor(current_floor), .up_ndown(up_ndown),
        .motor_up(motor_up), .motor_down(motor_down), .door_open(door_open),
        .queue_empty(queue_empty), .stop_served(stop_served), .fault(fault)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Behavioural model: mode, pending set, position, direction, door cycles left.
    int          m_mode, m_floor, m_left;
    bit          m_up, m_stop;
    bit [NF-1:0] m_pend;

    typedef struct {
        logic [NF-1:0] call;
        logic          tick;
        logic [FW-1:0] floor;
        logic          mu;
        logic          door;
        logic          stop;
        logic [NF-1:0] q;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] pack(input logic [NF-1:0] q, input logic [FW-1:0] f,
                                         input logic up, input logic mu, input logic md,
                                         input logic door, input logic empty,
                                         input logic stop, input logic flt);
        return {14'b0, q, f, up, mu, md, door, empty, stop, flt};
    endfunction

    function automatic logic [31:0] dut_bus();
        return pack(queue_status, current_floor, up_ndown, motor_up, motor_down,
                    door_open, queue_empty, stop_served, fault);
    endfunction

    function automatic logic [31:0] model_bus();
        return pack(m_pend, 3'(m_floor), m_up, m_mode == M_MOVE && m_up,
                    m_mode == M_MOVE && !m_up, m_mode == M_DOOR, m_pend == 0,
                    m_stop, m_mode == M_FAULT);
    endfunction

    function automatic bit resolve(input bit [NF-1:0] p, input int f, input bit cur);
        bit a, b;
        a = (32'(p) >> (f + 1)) != 0;
        b = (32'(p) & ((32'd1 << f) - 1)) != 0;
        if (a && !b) return 1'b1;
        if (b && !a) return 1'b0;
        return cur;
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_pend = '0; m_floor = 0; m_up = 1'b1; m_left = 0; m_stop = 1'b0;
    endtask

    task automatic model_open_door();
        m_mode = M_DOOR;
        m_left = DW;
        m_stop = 1'b1;
        m_pend[m_floor] = 1'b0;
    endtask

    task automatic model_step(input bit [NF-1:0] c, input bit t);
        bit [NF-1:0] pn;
        m_stop = 1'b0;
        if (m_mode == M_FAULT) return;
        pn = m_pend | c;
        m_pend = pn;
        if (t && (m_mode != M_MOVE || (m_up && m_floor == NF - 1) || (!m_up && m_floor == 0))) begin
            m_mode = M_FAULT;
            return;
        end
        case (m_mode)
            M_IDLE: begin
                if (pn[m_floor]) model_open_door();
                else if (pn != 0) begin
                    m_up = resolve(pn, m_floor, m_up);
                    m_mode = M_MOVE;
                end
            end
            M_MOVE: begin
                if (t) begin
                    m_floor = m_up ? m_floor + 1 : m_floor - 1;
                    if (pn[m_floor]) model_open_door();
                end
            end
            M_DOOR: begin
                m_pend[m_floor] = 1'b0;
                if (c[m_floor]) m_left = DW;
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        m_mode = M_IDLE;
                        m_up = resolve(m_pend, m_floor, m_up);
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic cycle(input logic [NF-1:0] c, input bit t, input string name);
        call_req = c;
        floor_tick = t;
        @(posedge clk);
        model_step(c, t);
        #1;
        check(name, dut_bus(), model_bus());
        call_req = '0;
        floor_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        #2;
        check("reset_async", dut_bus(), pack(8'h00, 3'd0, 1, 0, 0, 0, 1, 0, 0));
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic go_to_door(input string name);
        int budget = 100;
        while (m_mode != M_DOOR && budget > 0) begin
            cycle('0, m_mode == M_MOVE, name);
            budget--;
        end
        if (m_mode != M_DOOR) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic finish_door(input string name);
        int budget = 100;
        while (m_mode == M_DOOR && budget > 0) begin
            cycle('0, 1'b0, name);
            budget--;
        end
        if (m_mode == M_DOOR) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        bit q2_seen;
        logic [NF-1:0] rc;
        bit rt;

        vecs[0] = '{8'h20, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'h20};
        vecs[1] = '{8'h00, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, 8'h20};
        vecs[2] = '{8'h00, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0, 8'h20};
        vecs[3] = '{8'h00, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 8'h20};
        vecs[4] = '{8'h00, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 8'h20};
        vecs[5] = '{8'h00, 1'b1, 3'd5, 1'b0, 1'b1, 1'b1, 8'h00};
        vecs[6] = '{8'h00, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[7] = '{8'h00, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[8] = '{8'h00, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[9] = '{8'h00, 1'b0, 3'd5, 1'b0, 1'b0, 1'b0, 8'h00};

        call_req = '0;
        floor_tick = 1'b0;
        reset = 1'b1;
        model_reset();
        do_reset();

        // Idle after reset.
        for (int i = 0; i < 20; i++) begin
            cycle('0, 1'b0, "idle_model");
            check("idle_const", dut_bus(), pack(8'h00, 3'd0, 1, 0, 0, 0, 1, 0, 0));
        end

        // Call floor 5 from floor 0: table of per-cycle expectations.
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].call, vecs[i].tick, "vec_model");
            check($sformatf("vec%0d", i), dut_bus(),
                  pack(vecs[i].q, vecs[i].floor, 1'b1, vecs[i].mu, 1'b0, vecs[i].door,
                       vecs[i].q == 0, vecs[i].stop, 1'b0));
        end

        // Reversal: at 3 heading to 6, floor 1 called on the tick into 4.
        do_reset();
        cycle(8'h08, 1'b0, "s3_call3");
        go_to_door("s3_to3");
        finish_door("s3_door3");
        cycle(8'h40, 1'b0, "s3_call6");
        cycle(8'h02, 1'b1, "s3_tick4_call1");
        go_to_door("s3_to6");
        check("s3_first_stop", 32'(current_floor), 32'd6);
        finish_door("s3_door6");
        check("s3_reverse_dir", 32'(up_ndown), 32'd0);
        check("s3_pending1", 32'(queue_status), 32'h02);
        go_to_door("s3_to1");
        check("s3_second_stop", 32'(current_floor), 32'd1);
        finish_door("s3_door1");
        check("s3_empty", 32'(queue_empty), 32'd1);

        // Door re-call at floor 2 with one dwell cycle left.
        do_reset();
        cycle(8'h04, 1'b0, "s4_call2");
        go_to_door("s4_to2");
        cycle('0, 1'b0, "s4_dwell");
        cycle('0, 1'b0, "s4_dwell");
        cycle(8'h04, 1'b0, "s4_recall");
        cnt = door_open ? 1 : 0;
        q2_seen = queue_status[2];
        for (int i = 0; i < 10 && door_open; i++) begin
            cycle('0, 1'b0, "s4_hold");
            if (door_open) cnt++;
            q2_seen |= queue_status[2];
        end
        check("s4_door_len", 32'(cnt), 32'd4);
        check("s4_q2_never_set", 32'(q2_seen), 32'd0);

        // Spurious tick at top floor while stopped: sticky fault, then async reset.
        do_reset();
        cycle(8'h80, 1'b0, "s5_call7");
        go_to_door("s5_to7");
        cycle('0, 1'b1, "s5_bad_tick");
        check("s5_fault", dut_bus(), pack(8'h00, 3'd7, 1, 0, 0, 0, 1, 0, 1));
        for (int i = 0; i < 5; i++) cycle(8'h09, 1'b0, "s5_frozen");
        check("s5_frozen_const", dut_bus(), pack(8'h00, 3'd7, 1, 0, 0, 0, 1, 0, 1));
        do_reset();

        // Call arriving with the tick into floor 4 while heading to 6.
        cycle(8'h40, 1'b0, "s6_call6");
        for (int i = 0; i < 3; i++) cycle('0, 1'b1, "s6_tick");
        cycle(8'h10, 1'b1, "s6_same_cycle");
        check("s6_stop4", dut_bus(), pack(8'h40, 3'd4, 1, 0, 0, 1, 0, 1, 0));
        finish_door("s6_door4");
        go_to_door("s6_to6");
        check("s6_stop6", 32'(current_floor), 32'd6);
        finish_door("s6_door6");

        // Randomized legal traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rc = ($urandom_range(0, 5) == 0) ? (8'd1 << $urandom_range(0, 7)) : 8'd0;
            rt = (m_mode == M_MOVE) && ($urandom_range(0, 2) == 0) &&
                 !(m_up && m_floor == NF - 1) && !(!m_up && m_floor == 0);
            cycle(rc, rt, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
